alu_issue: RTL
==============

# alu_issue

Issue/retire sequencer on the request side of the ALU's `ALU_en`/`ALU_vld`/`ALU_ack` handshake. It accepts one decoded arithmetic or jump instruction per handshake and holds the ALU operands stable. It pulses `ALU_en`, waits for `ALU_vld`, and acknowledges with `ALU_ack`. It then retires the result as an accumulator write (arithmetic ops) or a PC write (jumps, resolved from `eq`/`gt`/`ge`/`set`). It sits in the axis_cpu datapath between the decoder and the ALU.

## Interface
Parameters:
- PC_WIDTH, 10, program counter width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- instr_vld  in  1  decoded instruction valid.
- instr_rdy  out  1  ready to accept an instruction.
- instr_is_jmp  in  1  1 = jump, 0 = ALU op.
- instr_op  in  4  ALU opcode (ADD..MOD encoding).
- instr_cond  in  3  jump condition (JA/JEQ/JGT/JGE/JSET).
- instr_use_k  in  1  B operand select: 1 = instr_k, 0 = x.
- instr_k  in  32  immediate.
- instr_jt, instr_jf  in  8 each  jump-true / jump-false offsets.
- instr_pc  in  PC_WIDTH  PC of this instruction.
- acc, x  in  32 each  current A and X register values.
- A, B  out  32 each  ALU operands.
- ALU_sel  out  4  ALU opcode.
- ALU_en  out  1  ALU start pulse.
- ALU_out  in  32  ALU result.
- eq, gt, ge, set  in  1 each  ALU predicates.
- ALU_vld  in  1  ALU result valid.
- ALU_ack  out  1  ALU result consumed.
- acc_wr_en  out  1  accumulator write strobe.
- acc_wr_data  out  32  accumulator write data.
- pc_wr_en  out  1  PC write strobe.
- pc_wr_data  out  PC_WIDTH  next PC.
- trap  out  1  sticky divide-by-zero trap.
- busy  out  1  high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, TRAP.

IDLE:
- `instr_rdy`=1.
- On `instr_vld && instr_rdy`, latch all instr_* fields, plus `acc` and (`instr_use_k` ? `instr_k` : `x`), into holding registers. Go to ISSUE.

ISSUE:
- `A`/`B`/`ALU_sel` are driven from the holding registers. They stay constant through WAIT.
- For jumps, `ALU_sel`=SUB.
- For a JA jump: no `ALU_en`. Assert `pc_wr_en` with `instr_pc+1+jt`, then go to IDLE.
- For all other instructions: `ALU_en`=1 for exactly this cycle, then go to WAIT.

WAIT:
- While `ALU_vld`=0, hold.
- When `ALU_vld`=1, in the same cycle: `ALU_ack`=1 (combinational), plus one retire strobe, then go to IDLE.
  - ALU op: `acc_wr_en`=1, `acc_wr_data`=`ALU_out`.
  - Jump: `pc_wr_en`=1, `pc_wr_data` = `instr_pc` + 1 + (pred ? `jt` : `jf`).
- pred is selected by condition: JEQ→`eq`, JGT→`gt`, JGE→`ge`, JSET→`set`.

Arithmetic and width rules:
- Offsets are zero-extended to PC_WIDTH. The PC sum wraps modulo 2^PC_WIDTH.
- Undefined opcodes (11–15) are issued unchanged. Whatever `ALU_out` returns is written back.

Other rules:
- `ALU_vld` seen in IDLE or ISSUE is ignored and not acknowledged.
- `ALU_ack` is asserted only in WAIT.
- At most one of `acc_wr_en`/`pc_wr_en` is high in any cycle. Each strobe is a single-cycle pulse.
- Instructions are never accepted outside IDLE.

## Timing
- Reset values: `instr_rdy`=1. All other outputs 0: `A`, `B`, `ALU_sel`, `ALU_en`, `ALU_ack`, `acc_wr_en`, `acc_wr_data`, `pc_wr_en`, `pc_wr_data`, `trap`, `busy`. State=IDLE.
- Reset mid-operation: immediate return to IDLE, all strobes drop asynchronously, the holding registers clear, and any pending `ALU_vld` is abandoned without ack.
- Single-cycle op (ALU responds one cycle after `ALU_en`):
  - cycle 0: accept.
  - cycle 1: `ALU_en`.
  - cycle 2: `ALU_vld`/`ALU_ack`/write.
  - cycle 3: IDLE with `instr_rdy`=1.
  - Throughput: one instruction per 3 cycles.
- Multi-cycle ops (MUL/DIV/MOD) stretch WAIT for as long as `ALU_vld` stays low. There is no timeout.
- JA retires in cycle 1; the next instruction is accepted in cycle 2.

## Configuration
- `AXIS_CPU_DIV0_TRAP_EN` defined:
  - In ISSUE, if `ALU_sel` is DIV or MOD and `B`==0: no `ALU_en`, no writeback, go to TRAP.
  - TRAP: `trap`=1, `instr_rdy`=0, `busy`=1. The block stays there until reset.
- Not defined:
  - The TRAP state is absent and `trap` is tied to 0.
  - DIV/MOD by zero are issued normally and the ALU's result is written back.

## Structure
- Opcode encodings (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, LSH=6, RSH=7, MUL=8, DIV=9, MOD=10) and jump conditions (JA=0, JEQ=1, JGT=2, JGE=3, JSET=4) come from `axis_cpu_defs.vh`. The jump-condition encodings are added there.
- Sub-module `jmp_resolve`: combinational predicate select plus PC adder. Parameterised by PC_WIDTH.

## Test plan
- ADD, `acc`=5, `instr_k`=7, `use_k`=1, ALU responds next cycle → `ALU_en` in cycle 1; in cycle 2, `ALU_ack`=1, `acc_wr_en`=1, `acc_wr_data`=12; `instr_rdy`=1 in cycle 3.
- DIV with `ALU_vld` delayed 33 cycles → `A`/`B`/`ALU_sel` stable throughout; exactly one `ALU_ack`, and it coincides with `ALU_vld`.
- JGT, `pc`=1023, `PC_WIDTH`=10, `jt`=4, `jf`=0, `gt`=1 → `pc_wr_data`=4 (wrap); with `gt`=0 → `pc_wr_data`=0.
- JA, `pc`=10, `jt`=3 → no `ALU_en`, `pc_wr_en` in cycle 1 with value 14.
- MOD with `x`=0, `use_k`=0: with the macro → `trap`=1, no `ALU_en`, `instr_rdy` stays 0; without the macro → issued, written back.
- `rst_n` low during WAIT with `ALU_vld`=1 → `ALU_ack` never asserts, all outputs at reset values, `instr_rdy`=1 the cycle after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared encodings and holding-register layout for the ALU issue/retire sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_issue_pkg;

    // ALU opcodes, mirrored from the axis_cpu decoder encodings
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_LSH = 4'd6;
    localparam logic [3:0] OP_RSH = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_MOD = 4'd10;

    // Jump conditions
    localparam logic [2:0] COND_JA   = 3'd0;
    localparam logic [2:0] COND_JEQ  = 3'd1;
    localparam logic [2:0] COND_JGT  = 3'd2;
    localparam logic [2:0] COND_JGE  = 3'd3;
    localparam logic [2:0] COND_JSET = 3'd4;

    // Sequencer states; TRAP only exists when the divide-by-zero trap is built in
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
`ifdef AXIS_CPU_DIV0_TRAP_EN
        ,
        ST_TRAP  = 2'd3
`endif
    } state_t;

    // Everything captured at accept time (PC kept separately since it is parameterised)
    typedef struct packed {
        logic        is_jmp;
        logic [2:0]  cond;
        logic [7:0]  jt;
        logic [7:0]  jf;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } hold_t;

    // Opcodes whose divisor must be non-zero
    function automatic logic is_div_op(input logic [3:0] sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_issue_jmp_resolve.sv
// Jump resolution: selects the branch predicate and forms pc + 1 + offset.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is used.
module jmp_resolve
    import alu_issue_pkg::*;
#(
    parameter int PC_WIDTH = 10
) (
    input  logic [2:0]          cond,
    input  logic                eq,
    input  logic                gt,
    input  logic                ge,
    input  logic                set,
    input  logic [7:0]          jt,
    input  logic [7:0]          jf,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] next_pc
);

    // Sum wide enough for either operand; the top bits are dropped so the PC wraps
    localparam int SW = ((PC_WIDTH > 8) ? PC_WIDTH : 8) + 1;

    logic          pred;
    logic [7:0]    offset;
    logic [SW-1:0] sum;

    // Predicate select; JA always takes jt, unknown conditions fall through to jf
    always_comb begin
        pred = 1'b0;
        case (cond)
            COND_JA:   pred = 1'b1;
            COND_JEQ:  pred = eq;
            COND_JGT:  pred = gt;
            COND_JGE:  pred = ge;
            COND_JSET: pred = set;
            default:   pred = 1'b0;
        endcase
    end

    // Zero-extended offset added to pc + 1, truncated modulo 2^PC_WIDTH
    always_comb begin
        offset  = pred ? jt : jf;
        sum     = SW'(pc) + SW'(offset) + SW'(1);
        next_pc = sum[PC_WIDTH-1:0];
    end

endmodule

// File: rtl/alu_issue.sv
// Issue/retire sequencer on the ALU request side; optional div-by-zero trap via AXIS_CPU_DIV0_TRAP_EN.
// Latency: accept -> ALU_en next cycle -> retire on the ALU_vld cycle; JA retires the cycle after accept.
// Backpressure: instr_rdy only in IDLE; WAIT holds operands until ALU_vld, acked combinationally.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int PC_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_vld,
    output logic                instr_rdy,
    input  logic                instr_is_jmp,
    input  logic [3:0]          instr_op,
    input  logic [2:0]          instr_cond,
    input  logic                instr_use_k,
    input  logic [31:0]         instr_k,
    input  logic [7:0]          instr_jt,
    input  logic [7:0]          instr_jf,
    input  logic [PC_WIDTH-1:0] instr_pc,
    input  logic [31:0]         acc,
    input  logic [31:0]         x,
    output logic [31:0]         A,
    output logic [31:0]         B,
    output logic [3:0]          ALU_sel,
    output logic                ALU_en,
    input  logic [31:0]         ALU_out,
    input  logic                eq,
    input  logic                gt,
    input  logic                ge,
    input  logic                set,
    input  logic                ALU_vld,
    output logic                ALU_ack,
    output logic                acc_wr_en,
    output logic [31:0]         acc_wr_data,
    output logic                pc_wr_en,
    output logic [PC_WIDTH-1:0] pc_wr_data,
    output logic                trap,
    output logic                busy
);

    state_t              state;
    state_t              state_nxt;
    hold_t               hold;
    logic [PC_WIDTH-1:0] hold_pc;
    logic [PC_WIDTH-1:0] jmp_pc;
    logic                accept;
    logic                is_ja;

    assign accept = (state == ST_IDLE) && instr_vld;
    assign is_ja  = hold.is_jmp && (hold.cond == COND_JA);

`ifdef AXIS_CPU_DIV0_TRAP_EN
    logic div0;
    assign div0 = !hold.is_jmp && is_div_op(hold.sel) && (hold.b == 32'd0);
`endif

    // Holding registers: captured on accept, stable through ISSUE and WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            hold_pc <= '0;
        end else if (accept) begin
            hold.is_jmp <= instr_is_jmp;
            hold.cond   <= instr_cond;
            hold.jt     <= instr_jt;
            hold.jf     <= instr_jf;
            hold.sel    <= instr_is_jmp ? OP_SUB : instr_op;
            hold.a      <= acc;
            hold.b      <= instr_use_k ? instr_k : x;
            hold_pc     <= instr_pc;
        end
    end

    // Operands are presented straight from the holding registers
    assign A       = hold.a;
    assign B       = hold.b;
    assign ALU_sel = hold.sel;

    jmp_resolve #(
        .PC_WIDTH (PC_WIDTH)
    ) u_jmp_resolve (
        .cond    (hold.cond),
        .eq      (eq),
        .gt      (gt),
        .ge      (ge),
        .set     (set),
        .jt      (hold.jt),
        .jf      (hold.jf),
        .pc      (hold_pc),
        .next_pc (jmp_pc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake/retire strobes
    always_comb begin
        state_nxt = state;
        instr_rdy = 1'b0;
        ALU_en    = 1'b0;
        ALU_ack   = 1'b0;
        acc_wr_en = 1'b0;
        pc_wr_en  = 1'b0;
        trap      = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                instr_rdy = 1'b1;
                if (instr_vld) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (is_ja) begin
                    // Unconditional jump needs no ALU round trip
                    pc_wr_en  = 1'b1;
                    state_nxt = ST_IDLE;
`ifdef AXIS_CPU_DIV0_TRAP_EN
                end else if (div0) begin
                    state_nxt = ST_TRAP;
`endif
                end else begin
                    ALU_en    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ALU_vld) begin
                    ALU_ack   = 1'b1;
                    pc_wr_en  = hold.is_jmp;
                    acc_wr_en = !hold.is_jmp;
                    state_nxt = ST_IDLE;
                end
            end
`ifdef AXIS_CPU_DIV0_TRAP_EN
            ST_TRAP: begin
                // Sticky until reset
                trap = 1'b1;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write data is only non-zero alongside its strobe
    assign acc_wr_data = acc_wr_en ? ALU_out : 32'd0;
    assign pc_wr_data  = pc_wr_en ? jmp_pc : '0;

endmodule
